data_block_gen2: RTL and testbench
==================================

// Module: data_block_gen2
// PURPOSE
//  Second-generation parametrised S8SP datapath: AR, DR, PR, IR, a general-register file,
//  a registered ALU with flags, and a multi-cycle shift-add multiplier.
//  Sits between the controller (all select/load strobes, ir_code) and the system data/address buses.
//  New over gen1: configurable widths/GR count, encoded single-driver bus select, registered ALU/flags, MUL.
// PARAMETERS
//  DW   8  data width; must be even, >= 4
//  AW   8  address width; AW <= DW, loaded from data_bus[AW-1:0], zero-extended when driven to data_bus
//  NGR  4  number of general registers; power of two, >= 2; GW = log2(NGR)
// PORTS
//  clk          in     1     system clock, all state on rising edge
//  reset        in     1     synchronous, active-high
//  data_bus     inout  DW    system data bus
//  addr_bus     out    AW    system address bus, tri-state
//  load_ar      in     1     AR <= data_bus[AW-1:0]
//  ar_on_addr   in     1     AR drives addr_bus
//  load_dr      in     1     DR <= data_bus
//  gr_wr_sel    in     GW    GR write index
//  load_lo_gr   in     1     GR[gr_wr_sel] low half  <= data_bus[DW/2-1:0]
//  load_hi_gr   in     1     GR[gr_wr_sel] high half <= data_bus[DW/2-1:0]
//  gr_a_sel     in     GW    GR index for operand A and for bus source 2
//  gr_b_sel     in     GW    GR index for operand B
//  load_pr      in     1     PR <= data_bus[AW-1:0]
//  inc_pr       in     1     PR <= PR+1
//  pr_on_addr   in     1     PR drives addr_bus
//  load_ir      in     1     IR <= data_bus
//  ir_code      out    DW    IR contents to controller
//  src_en       in     1     datapath drives data_bus
//  src_sel      in     3     0 AR,1 DR,2 GR[gr_a_sel],3 PR,4 RES,5 {0,FLAGS},6 IR,7 MULHI
//  opa_sel      in     2     operand A: 0 AR,1 DR,2 GR[gr_a_sel],3 PR
//  opb_sel      in     2     operand B: 0 AR,1 DR,2 GR[gr_b_sel],3 PR
//  alu_op       in     3     0 ADD,1 SUB,2 ADC,3 SBC,4 AND,5 OR,6 XOR,7 PASSA
//  alu_go       in     1     capture ALU result into RES and flags
//  mul_start    in     1     start unsigned A*B
//  mul_busy     out    1     multiplier in BUSY
//  mul_done     out    1     one-cycle pulse, product valid
//  flags        out    4     {V,N,Z,C}
// BEHAVIOUR
//  Reset: AR,DR,PR,IR,all GR,RES,MULHI,flags = 0; MUL FSM IDLE; mul_busy=mul_done=0; buses Z.
//  data_bus driven only when src_en=1 (single encoded driver, no contention possible); else Z.
//  addr_bus: ar_on_addr wins over pr_on_addr; neither -> Z.
//  PR: reset > load_pr > inc_pr; 2^AW-1 +1 wraps to 0.
//  GR: load_lo_gr and load_hi_gr same cycle -> both halves take data_bus[DW/2-1:0] (duplicated).
//  Loads take effect at the edge they are sampled; new value visible next cycle.
//  ALU combinational on A/B; alu_go registers RES and flags at that edge (latency 1).
//   ADD/ADC: {C,RES}=A+B(+C); SUB/SBC: RES=A-B(-C), C=1 on borrow.
//   V=two's-complement overflow for arith ops; logic/PASSA: C=0,V=0.
//   Z=(RES==0), N=RES[DW-1] for all ops.
//  MUL FSM IDLE->BUSY->DONE->IDLE:
//   IDLE: mul_start latches A,B; count=0; -> BUSY.
//   BUSY: one shift-add step per cycle, exactly DW cycles, mul_busy=1; then -> DONE.
//   DONE: {MULHI,RES}=product written on entry; mul_done=1 for this cycle only;
//         Z=(product==0), C=(MULHI!=0), N=V=0; -> IDLE.
//   mul_start outside IDLE ignored; alu_go while BUSY or DONE ignored.
//   mul_start and alu_go together in IDLE: MUL starts, alu_go ignored.
//   Operand/source register changes during BUSY do not affect the product.
//  Reset mid-MUL: FSM to IDLE same edge, partial product discarded, no mul_done.
// TESTING (DW=8,AW=8,NGR=4)
//  A=0x7F,B=0x01,ADD,alu_go -> RES=0x80,{V,N,Z,C}=1100; src_sel=4 -> data_bus=0x80 next cycle
//  A=0x00,B=0x01,SUB then SBC with A=B=0x00 -> RES=0xFF,C=1; then RES=0xFF,C=1
//  A=B=0xFF,mul_start at cycle 0 -> busy cycles 1..8, mul_done at cycle 9, MULHI=0xFE,RES=0x01,C=1
//  PR=0xFF,inc_pr -> 0x00; load_pr=inc_pr=1,data_bus=0x42 -> PR=0x42; both addr enables -> addr_bus=AR
//  GR[2] load_lo 0x5,load_hi 0xA -> GR[2]=0xA5; src_en=0 -> data_bus=Z; src_sel=5 -> 0x0 and flags
//  reset at BUSY cycle 4 -> mul_busy=0 next cycle, no mul_done, RES=MULHI=0, PR=0

Source files
------------

// File: rtl/data_block_gen2.sv
// S8SP gen2 datapath: AR/DR/PR/IR, general-register file, registered ALU with flags
// and a shift-add multiplier, between the controller strobes and the system buses.
module data_block_gen2 #(
    parameter int DW  = 8,
    parameter int AW  = 8,
    parameter int NGR = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    inout  wire  [DW-1:0]           data_bus,
    output wire  [AW-1:0]           addr_bus,
    input  logic                    load_ar,
    input  logic                    ar_on_addr,
    input  logic                    load_dr,
    input  logic [$clog2(NGR)-1:0]  gr_wr_sel,
    input  logic                    load_lo_gr,
    input  logic                    load_hi_gr,
    input  logic [$clog2(NGR)-1:0]  gr_a_sel,
    input  logic [$clog2(NGR)-1:0]  gr_b_sel,
    input  logic                    load_pr,
    input  logic                    inc_pr,
    input  logic                    pr_on_addr,
    input  logic                    load_ir,
    output logic [DW-1:0]           ir_code,
    input  logic                    src_en,
    input  logic [2:0]              src_sel,
    input  logic [1:0]              opa_sel,
    input  logic [1:0]              opb_sel,
    input  logic [2:0]              alu_op,
    input  logic                    alu_go,
    input  logic                    mul_start,
    output logic                    mul_busy,
    output logic                    mul_done,
    output logic [3:0]              flags
);
    localparam int HW = DW / 2;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

    logic [AW-1:0]   ar_q, ar_d, pr_q, pr_d;
    logic [DW-1:0]   dr_q, dr_d, ir_q, ir_d, res_q, res_d, mulhi_q, mulhi_d, mcand_q, mcand_d;
    logic [DW-1:0]   gr_q [NGR];
    logic [DW-1:0]   gr_d [NGR];
    logic [3:0]      flags_q, flags_d;
    logic [2*DW-1:0] prod_q, prod_d, prod_step;
    logic [CW-1:0]   count_q, count_d;
    mul_state_t      state_q, state_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic [DW-1:0]   opa, opb, bus_src, alu_res, addend;
    logic [DW:0]     alu_wide, step_sum;
    logic            is_arith, is_sub, alu_c, alu_v;

    assign data_bus = src_en ? bus_src : {DW{1'bz}};
    assign addr_bus = ar_on_addr ? ar_q : (pr_on_addr ? pr_q : {AW{1'bz}});
    assign ir_code  = ir_q;
    assign flags    = flags_q;
    assign mul_busy = busy_q;
    assign mul_done = done_q;

    always_comb begin
        opa = DW'(ar_q);
        case (opa_sel)
            2'd1:    opa = dr_q;
            2'd2:    opa = gr_q[gr_a_sel];
            2'd3:    opa = DW'(pr_q);
            default: opa = DW'(ar_q);
        endcase
        opb = DW'(ar_q);
        case (opb_sel)
            2'd1:    opb = dr_q;
            2'd2:    opb = gr_q[gr_b_sel];
            2'd3:    opb = DW'(pr_q);
            default: opb = DW'(ar_q);
        endcase
        bus_src = DW'(ar_q);
        case (src_sel)
            3'd1:    bus_src = dr_q;
            3'd2:    bus_src = gr_q[gr_a_sel];
            3'd3:    bus_src = DW'(pr_q);
            3'd4:    bus_src = res_q;
            3'd5:    bus_src = DW'(flags_q);
            3'd6:    bus_src = ir_q;
            3'd7:    bus_src = mulhi_q;
            default: bus_src = DW'(ar_q);
        endcase
    end

    // Subtraction runs in DW+1 bits so the top bit is the borrow.
    always_comb begin
        alu_wide = '0;
        is_arith = 1'b1;
        is_sub   = 1'b0;
        case (alu_op)
            3'd0: alu_wide = {1'b0, opa} + {1'b0, opb};
            3'd1: begin alu_wide = {1'b0, opa} - {1'b0, opb}; is_sub = 1'b1; end
            3'd2: alu_wide = {1'b0, opa} + {1'b0, opb} + (DW+1)'(flags_q[0]);
            3'd3: begin alu_wide = {1'b0, opa} - {1'b0, opb} - (DW+1)'(flags_q[0]); is_sub = 1'b1; end
            3'd4: begin alu_wide = {1'b0, opa & opb}; is_arith = 1'b0; end
            3'd5: begin alu_wide = {1'b0, opa | opb}; is_arith = 1'b0; end
            3'd6: begin alu_wide = {1'b0, opa ^ opb}; is_arith = 1'b0; end
            default: begin alu_wide = {1'b0, opa}; is_arith = 1'b0; end
        endcase
        alu_res = alu_wide[DW-1:0];
        alu_c   = is_arith & alu_wide[DW];
        alu_v   = is_arith & (is_sub ? (opa[DW-1] != opb[DW-1]) : (opa[DW-1] == opb[DW-1]))
                  & (alu_res[DW-1] != opa[DW-1]);
    end

    // One shift-add step: multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        addend    = prod_q[0] ? mcand_q : '0;
        step_sum  = {1'b0, prod_q[2*DW-1:DW]} + {1'b0, addend};
        prod_step = {step_sum, prod_q[DW-1:1]};
    end

    // Multiplier protocol: mul_start is accepted only in IDLE; mul_busy is high for
    // exactly DW cycles; mul_done pulses one cycle with {MULHI,RES} already valid.
    always_comb begin
        ar_d    = load_ar ? data_bus[AW-1:0] : ar_q;
        dr_d    = load_dr ? data_bus : dr_q;
        ir_d    = load_ir ? data_bus : ir_q;
        pr_d    = load_pr ? data_bus[AW-1:0] : (inc_pr ? pr_q + AW'(1) : pr_q);
        gr_d    = gr_q;
        if (load_lo_gr) gr_d[gr_wr_sel][HW-1:0]  = data_bus[HW-1:0];
        if (load_hi_gr) gr_d[gr_wr_sel][DW-1:HW] = data_bus[HW-1:0];
        res_d   = res_q;
        mulhi_d = mulhi_q;
        flags_d = flags_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        count_d = count_q;
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    mcand_d = opa;
                    prod_d  = {{DW{1'b0}}, opb};
                    count_d = '0;
                    state_d = S_BUSY;
                end else if (alu_go) begin
                    res_d   = alu_res;
                    flags_d = {alu_v, alu_res[DW-1], alu_res == '0, alu_c};
                end
            end
            S_BUSY: begin
                prod_d  = prod_step;
                count_d = count_q + CW'(1);
                if (count_q == CW'(DW - 1)) begin
                    res_d   = prod_step[DW-1:0];
                    mulhi_d = prod_step[2*DW-1:DW];
                    flags_d = {1'b0, 1'b0, prod_step == '0, prod_step[2*DW-1:DW] != '0};
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_BUSY);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_q    <= '0;
            dr_q    <= '0;
            pr_q    <= '0;
            ir_q    <= '0;
            for (int i = 0; i < NGR; i++) gr_q[i] <= '0;
            res_q   <= '0;
            mulhi_q <= '0;
            flags_q <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
            count_q <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            ar_q    <= ar_d;
            dr_q    <= dr_d;
            pr_q    <= pr_d;
            ir_q    <= ir_d;
            gr_q    <= gr_d;
            res_q   <= res_d;
            mulhi_q <= mulhi_d;
            flags_q <= flags_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            count_q <= count_d;
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_data_block_gen2.sv
// Bench for data_block_gen2 (DW=8, AW=8, NGR=4): directed and randomized steps
// checked against an arithmetic reference model of the register/ALU/MUL behaviour.
module tb_data_block_gen2;
    logic       clk = 1'b0;
    logic       reset;
    wire  [7:0] data_bus;
    wire  [7:0] addr_bus;
    logic       load_ar, ar_on_addr, load_dr, load_lo_gr, load_hi_gr;
    logic [1:0] gr_wr_sel, gr_a_sel, gr_b_sel, opa_sel, opb_sel;
    logic       load_pr, inc_pr, pr_on_addr, load_ir, src_en, alu_go, mul_start;
    logic [2:0] src_sel, alu_op;
    logic [7:0] ir_code;
    logic       mul_busy, mul_done;
    logic [3:0] flags;

    logic       tb_drive;
    logic [7:0] tb_data;
    assign data_bus = tb_drive ? tb_data : 8'bz;
    pullup   (data_bus);
    pulldown (addr_bus);

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [7:0] m_ar, m_dr, m_pr, m_ir, m_res, m_mulhi;
    logic [7:0] m_gr [4];
    logic [3:0] m_flags;

    data_block_gen2 #(.DW(8), .AW(8), .NGR(4)) dut (
        .clk(clk), .reset(reset), .data_bus(data_bus), .addr_bus(addr_bus),
        .load_ar(load_ar), .ar_on_addr(ar_on_addr), .load_dr(load_dr),
        .gr_wr_sel(gr_wr_sel), .load_lo_gr(load_lo_gr), .load_hi_gr(load_hi_gr),
        .gr_a_sel(gr_a_sel), .gr_b_sel(gr_b_sel), .load_pr(load_pr), .inc_pr(inc_pr),
        .pr_on_addr(pr_on_addr), .load_ir(load_ir), .ir_code(ir_code), .src_en(src_en),
        .src_sel(src_sel), .opa_sel(opa_sel), .opb_sel(opb_sel), .alu_op(alu_op),
        .alu_go(alu_go), .mul_start(mul_start), .mul_busy(mul_busy), .mul_done(mul_done),
        .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        load_ar = 0; ar_on_addr = 0; load_dr = 0; load_lo_gr = 0; load_hi_gr = 0;
        gr_wr_sel = 0; gr_a_sel = 0; gr_b_sel = 0; opa_sel = 0; opb_sel = 0;
        load_pr = 0; inc_pr = 0; pr_on_addr = 0; load_ir = 0; src_en = 0;
        src_sel = 0; alu_op = 0; alu_go = 0; mul_start = 0; tb_drive = 0; tb_data = 0;
    endtask

    task automatic model_reset();
        m_ar = 0; m_dr = 0; m_pr = 0; m_ir = 0; m_res = 0; m_mulhi = 0; m_flags = 0;
        for (int i = 0; i < 4; i++) m_gr[i] = 0;
    endtask

    function automatic logic [7:0] opnd(input logic [1:0] sel, input logic [1:0] g);
        case (sel)
            2'd0:    return m_ar;
            2'd1:    return m_dr;
            2'd2:    return m_gr[g];
            default: return m_pr;
        endcase
    endfunction

    // Plain integer arithmetic: carry/borrow from range of the unsigned result,
    // overflow from range of the signed result.
    task automatic model_alu(input int op, input int a, input int b, input int cin,
                             output logic [7:0] r, output logic [3:0] f);
        int sa, sb, full, sfull;
        logic c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0; v = 0; full = 0;
        case (op)
            0, 2: begin
                full  = a + b + ((op == 2) ? cin : 0);
                sfull = sa + sb + ((op == 2) ? cin : 0);
                c = (full > 255); v = (sfull > 127) || (sfull < -128);
            end
            1, 3: begin
                full  = a - b - ((op == 3) ? cin : 0);
                sfull = sa - sb - ((op == 3) ? cin : 0);
                c = (full < 0); v = (sfull > 127) || (sfull < -128);
            end
            4: full = a & b;
            5: full = a | b;
            6: full = a ^ b;
            default: full = a;
        endcase
        r = 8'(full & 255);
        f = {v, r >= 8'd128, r == 8'd0, c};
    endtask

    task automatic load_reg(input int which, input logic [7:0] v);
        tb_drive = 1; tb_data = v;
        case (which)
            0: begin load_ar = 1; m_ar = v; end
            1: begin load_dr = 1; m_dr = v; end
            3: begin load_pr = 1; m_pr = v; end
            default: begin load_ir = 1; m_ir = v; end
        endcase
        tick();
        load_ar = 0; load_dr = 0; load_pr = 0; load_ir = 0; tb_drive = 0;
    endtask

    task automatic load_gr(input logic [1:0] idx, input logic lo, input logic hi, input logic [7:0] v);
        tb_drive = 1; tb_data = v; gr_wr_sel = idx; load_lo_gr = lo; load_hi_gr = hi;
        if (lo) m_gr[idx][3:0] = v[3:0];
        if (hi) m_gr[idx][7:4] = v[3:0];
        tick();
        load_lo_gr = 0; load_hi_gr = 0; tb_drive = 0;
    endtask

    task automatic read_src(input logic [2:0] sel, input logic [1:0] ga, input logic [7:0] exp,
                            input string tag);
        src_sel = sel; gr_a_sel = ga; src_en = 1;
        #1;
        check(tag, data_bus, exp);
        src_en = 0;
    endtask

    task automatic do_alu(input logic [2:0] op, input logic [1:0] oa, input logic [1:0] ob,
                          input logic [1:0] ga, input logic [1:0] gb);
        logic [7:0] r;
        logic [3:0] f;
        model_alu(int'(op), int'(opnd(oa, ga)), int'(opnd(ob, gb)), int'(m_flags[0]), r, f);
        alu_op = op; opa_sel = oa; opb_sel = ob; gr_a_sel = ga; gr_b_sel = gb; alu_go = 1;
        tick();
        alu_go = 0;
        m_res = r; m_flags = f;
    endtask

    task automatic check_res_flags(input string tag);
        check({tag, "_flags"}, flags, m_flags);
        read_src(3'd4, 2'd0, m_res, {tag, "_res"});
    endtask

    task automatic mul_run(input logic [1:0] oa, input logic [1:0] ob, input logic [1:0] ga,
                           input logic [1:0] gb, input bit disturb);
        int prod;
        prod = int'(opnd(oa, ga)) * int'(opnd(ob, gb));
        opa_sel = oa; opb_sel = ob; gr_a_sel = ga; gr_b_sel = gb;
        mul_start = 1; alu_go = 1; alu_op = 3'd7;
        tick();
        mul_start = 0; alu_go = 0;
        for (int k = 1; k <= 8; k++) begin
            check("mul_busy", mul_busy, 1'b1);
            check("mul_done_early", mul_done, 1'b0);
            if (disturb && k == 3) begin
                tb_drive = 1; tb_data = 8'($urandom); load_ar = 1; load_dr = 1;
                mul_start = 1; alu_go = 1;
                m_ar = tb_data; m_dr = tb_data;
            end
            tick();
            load_ar = 0; load_dr = 0; mul_start = 0; alu_go = 0; tb_drive = 0;
        end
        m_res = 8'(prod & 255);
        m_mulhi = 8'((prod >> 8) & 255);
        m_flags = {2'b00, prod == 0, m_mulhi != 8'd0};
        check("mul_done", mul_done, 1'b1);
        check("mul_busy_done", mul_busy, 1'b0);
        check_res_flags("mul");
        read_src(3'd7, 2'd0, m_mulhi, "mul_hi");
        // both must be ignored in the DONE cycle
        mul_start = 1; alu_go = 1; alu_op = 3'd6; opa_sel = 2'd1; opb_sel = 2'd0;
        tick();
        mul_start = 0; alu_go = 0;
        check("mul_done_pulse", mul_done, 1'b0);
        check("mul_restart_ign", mul_busy, 1'b0);
        check_res_flags("mul_after");
    endtask

    initial begin
        logic [7:0] v;
        clear_inputs();
        model_reset();
        reset = 1;
        tick();
        tick();
        reset = 0;

        // reset state
        check("rst_busy", mul_busy, 1'b0);
        check("rst_done", mul_done, 1'b0);
        check("rst_flags", flags, 4'd0);
        check("rst_ir", ir_code, 8'd0);
        check("rst_data_z", data_bus, 8'hFF);
        check("rst_addr_z", addr_bus, 8'h00);
        for (int s = 0; s < 8; s++) read_src(3'(s), 2'd0, 8'd0, "rst_src");
        for (int g = 0; g < 4; g++) read_src(3'd2, 2'(g), 8'd0, "rst_gr");
        tick();

        // ADD overflow into sign bit
        load_reg(0, 8'h7F);
        load_reg(1, 8'h01);
        do_alu(3'd0, 2'd0, 2'd1, 2'd0, 2'd0);
        check("add_flags_const", flags, 4'b1100);
        read_src(3'd4, 2'd0, 8'h80, "add_res_const");
        check_res_flags("add");

        // SUB borrow, then SBC with carry-in
        load_reg(0, 8'h00);
        do_alu(3'd1, 2'd0, 2'd1, 2'd0, 2'd0);
        check_res_flags("sub");
        read_src(3'd4, 2'd0, 8'hFF, "sub_res_const");
        load_reg(1, 8'h00);
        do_alu(3'd3, 2'd0, 2'd1, 2'd0, 2'd0);
        check_res_flags("sbc");
        check("sbc_c_const", flags[0], 1'b1);
        read_src(3'd5, 2'd0, {4'd0, m_flags}, "flags_src");

        // MUL 0xFF * 0xFF with disturbance during BUSY
        load_reg(0, 8'hFF);
        load_reg(1, 8'hFF);
        mul_run(2'd0, 2'd1, 2'd0, 2'd0, 1'b1);
        read_src(3'd7, 2'd0, 8'hFE, "mul_hi_const");

        // PR wrap, load priority, addr mux
        load_reg(3, 8'hFF);
        inc_pr = 1; tick(); inc_pr = 0; m_pr = m_pr + 8'd1;
        read_src(3'd3, 2'd0, 8'h00, "pr_wrap");
        tb_drive = 1; tb_data = 8'h42; load_pr = 1; inc_pr = 1; tick();
        tb_drive = 0; load_pr = 0; inc_pr = 0; m_pr = 8'h42;
        read_src(3'd3, 2'd0, m_pr, "pr_load_pri");
        load_reg(0, 8'h3C);
        pr_on_addr = 1; #1; check("addr_pr", addr_bus, m_pr);
        ar_on_addr = 1; #1; check("addr_ar_wins", addr_bus, m_ar);
        ar_on_addr = 0; pr_on_addr = 0; #1; check("addr_z", addr_bus, 8'h00);
        tick();

        // GR half loads, IR
        load_gr(2'd2, 1'b1, 1'b0, 8'h05);
        load_gr(2'd2, 1'b0, 1'b1, 8'h0A);
        read_src(3'd2, 2'd2, 8'hA5, "gr2_halves");
        load_gr(2'd1, 1'b1, 1'b1, 8'h3C);
        read_src(3'd2, 2'd1, 8'hCC, "gr1_dup");
        load_reg(6, 8'h9D);
        check("ir_code", ir_code, m_ir);
        read_src(3'd6, 2'd0, m_ir, "ir_src");
        src_en = 0; #1; check("data_z", data_bus, 8'hFF);
        tick();

        // randomized ALU traffic
        for (int it = 0; it < 40; it++) begin
            load_reg($urandom_range(0, 1), 8'($urandom));
            load_gr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                inc_pr = 1; tick(); inc_pr = 0; m_pr = m_pr + 8'd1;
            end
            do_alu(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            check_res_flags("alu_rand");
            v = 8'($urandom_range(0, 3));
            read_src(3'd2, v[1:0], m_gr[v[1:0]], "gr_rand");
            tick();
        end

        // randomized MUL operands
        for (int it = 0; it < 4; it++) begin
            load_reg(0, 8'($urandom));
            load_gr(2'd3, 1'b1, 1'b1, 8'($urandom));
            mul_run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'd3, 2'd3, 1'($urandom_range(0, 1)));
        end
        load_reg(1, 8'h00);
        mul_run(2'd0, 2'd1, 2'd0, 2'd0, 1'b0);

        // reset in BUSY cycle 4
        load_reg(0, 8'h37);
        load_reg(1, 8'hB5);
        load_reg(3, 8'h21);
        mul_start = 1; tick(); mul_start = 0;
        tick(); tick(); tick();
        check("mid_busy", mul_busy, 1'b1);
        reset = 1; tick(); reset = 0;
        model_reset();
        check("rst_mid_busy", mul_busy, 1'b0);
        check("rst_mid_done", mul_done, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("rst_no_done", mul_done | mul_busy, 1'b0);
        end
        read_src(3'd4, 2'd0, m_res, "rst_mid_res");
        read_src(3'd7, 2'd0, m_mulhi, "rst_mid_hi");
        read_src(3'd3, 2'd0, m_pr, "rst_mid_pr");
        check("rst_mid_flags", flags, m_flags);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
